// File: rtl/ps2_modbus_frame_ctrl_if.sv
// Bundles the PS/2 byte input, the UART byte handshake and the status flags.
// slave: the frame controller. master: whatever sits around it (receiver, UART, bench).
// Timing and backpressure are defined by ps2_modbus_frame_ctrl.
interface ps2_modbus_frame_ctrl_if;
  logic [7:0] PS2_Data;
  logic       PS2_Done_Sig;
  logic [7:0] TX_Data;
  logic       TX_En_Sig;
  logic       TX_Done_Sig;
  logic       Busy_Sig;
  logic       Overflow_Sig;

  modport slave (
    input  PS2_Data, PS2_Done_Sig, TX_Done_Sig,
    output TX_Data, TX_En_Sig, Busy_Sig, Overflow_Sig
  );

  modport master (
    output PS2_Data, PS2_Done_Sig, TX_Done_Sig,
    input  TX_Data, TX_En_Sig, Busy_Sig, Overflow_Sig
  );
endinterface

// File: rtl/ps2_modbus_frame_ctrl.sv
// Turns PS/2 scan codes (E0/F0 prefixes folded in) into 7-byte Modbus-style frames sent byte-wise to a UART.
// Latency: first TX_En_Sig 42 clocks after an event is queued with the FSM idle; one idle cycle between frames.
// Backpressure: 2-entry event queue; a push into a full queue is dropped and sets sticky Overflow_Sig.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeated make codes.
module ps2_modbus_frame_ctrl #(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter logic [7:0] FUNC_CODE  = 8'h41,
  parameter logic [7:0] EXT_CODE   = 8'hE0,
  parameter logic [7:0] BRK_CODE   = 8'hF0
) (
  input logic                     CLK,
  input logic                     RSTn,
  ps2_modbus_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_CRC, ST_LOAD, ST_WAIT} state_t;

  // Event layout: {ext, brk, code}
  logic       ext_q, brk_q;
  logic [9:0] q0_q, q1_q;
  logic [1:0] cnt_q;
  logic       ovf_q;

  state_t      state_q;
  logic [9:0]  fr_ev_q;
  logic [2:0]  idx_q, bit_q;
  logic [15:0] crc_q;
  logic [7:0]  seq_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q, busy_q;

  logic        is_ext, is_brk, is_code, filt_drop, push, pop, accept;
  logic [9:0]  ev_d;
  logic [7:0]  frame_byte;
  logic [15:0] crc_in, crc_d;

  assign is_ext  = bus.PS2_Done_Sig && (bus.PS2_Data == EXT_CODE);
  assign is_brk  = bus.PS2_Done_Sig && (bus.PS2_Data == BRK_CODE);
  assign is_code = bus.PS2_Done_Sig && !is_ext && !is_brk;
  assign ev_d    = {ext_q, brk_q, bus.PS2_Data};

`ifdef TYPEMATIC_FILTER_EN
  logic       last_vld_q;
  logic [8:0] last_q;

  // A make equal to the remembered make is an auto-repeat.
  assign filt_drop = is_code && !brk_q && last_vld_q && (last_q == {ext_q, bus.PS2_Data});

  // Remember the last make; its matching break forgets it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_vld_q <= 1'b0;
      last_q     <= '0;
    end else if (is_code) begin
      if (brk_q) begin
        if (last_vld_q && (last_q == {ext_q, bus.PS2_Data})) last_vld_q <= 1'b0;
      end else if (!filt_drop) begin
        last_vld_q <= 1'b1;
        last_q     <= {ext_q, bus.PS2_Data};
      end
    end
  end
`else
  assign filt_drop = 1'b0;
`endif

  assign push   = is_code && !filt_drop;
  assign pop    = (state_q == ST_IDLE) && (cnt_q != 2'd0);
  // A pop in the same cycle frees the slot, so a push into a full queue still fits.
  assign accept = push && ((cnt_q != 2'd2) || pop);

  // Prefix flags, event queue and sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      q0_q  <= '0;
      q1_q  <= '0;
      cnt_q <= 2'd0;
      ovf_q <= 1'b0;
    end else begin
      if (is_ext) ext_q <= 1'b1;
      if (is_brk) brk_q <= 1'b1;
      if (is_code) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
      if (push && !accept) ovf_q <= 1'b1;
      case ({accept, pop})
        2'b10: begin
          if (cnt_q == 2'd0) q0_q <= ev_d;
          else               q1_q <= ev_d;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          q0_q  <= q1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) q0_q <= ev_d;
          else begin
            q0_q <= q1_q;
            q1_q <= ev_d;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame byte selected by idx; feeds both the CRC fold and the UART.
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      3'd0: frame_byte = SLAVE_ADDR;
      3'd1: frame_byte = FUNC_CODE;
      3'd2: frame_byte = {6'b0, fr_ev_q[9], fr_ev_q[8]};
      3'd3: frame_byte = fr_ev_q[7:0];
      3'd4: frame_byte = seq_q;
      3'd5: frame_byte = crc_q[7:0];
      3'd6: frame_byte = crc_q[15:8];
      default: frame_byte = 8'h00;
    endcase
  end

  // One reflected CRC16 step; the byte is xored in on its first bit.
  always_comb begin
    crc_in = (bit_q == 3'd0) ? (crc_q ^ {8'h00, frame_byte}) : crc_q;
    crc_d  = crc_in[0] ? ({1'b0, crc_in[15:1]} ^ 16'hA001) : {1'b0, crc_in[15:1]};
  end

  // Transmit sequencer: pop, fold CRC over B0..B4, then hand out B0..B6.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      fr_ev_q   <= '0;
      idx_q     <= 3'd0;
      bit_q     <= 3'd0;
      crc_q     <= 16'hFFFF;
      seq_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cnt_q != 2'd0) begin
            fr_ev_q <= q0_q;
            idx_q   <= 3'd0;
            bit_q   <= 3'd0;
            crc_q   <= 16'hFFFF;
            busy_q  <= 1'b1;
            state_q <= ST_CRC;
          end
        end
        ST_CRC: begin
          crc_q <= crc_d;
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (idx_q == 3'd4) begin
              idx_q   <= 3'd0;
              state_q <= ST_LOAD;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_LOAD: begin
          tx_data_q <= frame_byte;
          tx_en_q   <= 1'b1;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.TX_Done_Sig) begin
            if (idx_q == 3'd6) begin
              idx_q   <= 3'd0;
              seq_q   <= seq_q + 8'd1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.TX_Data      = tx_data_q;
  assign bus.TX_En_Sig    = tx_en_q;
  assign bus.Busy_Sig     = busy_q;
  assign bus.Overflow_Sig = ovf_q;

endmodule

// File: tb/tb_ps2_modbus_frame_ctrl.sv
// Bench for ps2_modbus_frame_ctrl: directed scenarios plus randomized key events
// checked against a byte-level model of parser, filter, queue and frame/CRC rules.
module tb_ps2_modbus_frame_ctrl;

  logic CLK = 1'b0;
  logic RSTn;
  int   cyc = 0;

  always #5 CLK = ~CLK;

  ps2_modbus_frame_ctrl_if bus_if();

  ps2_modbus_frame_ctrl dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus_if)
  );

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every TX_En_Sig cycle captures one byte and its cycle number.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  initial forever begin
    @(negedge CLK);
    if (bus_if.TX_En_Sig === 1'b1) begin
      got_q.push_back(bus_if.TX_Data);
      got_cyc.push_back(cyc);
    end
  end

  // UART model: finishes each byte 1..4 cycles after its start pulse.
  initial begin
    bus_if.TX_Done_Sig = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus_if.TX_En_Sig === 1'b1) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1 bus_if.TX_Done_Sig = 1'b1;
        @(posedge CLK);
        #1 bus_if.TX_Done_Sig = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int         gp = 0;
  int         m_queued = 0;
  bit         m_ext, m_brk, m_ovf, m_last_vld;
  logic [8:0] m_last;
  logic [7:0] m_seq;
  int         last_t0;

  function automatic logic [15:0] crc16(input logic [39:0] d);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      c = c ^ {8'h00, d[39 - 8*i -: 8]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic model_frame(input bit ext, input bit brk, input logic [7:0] code);
    logic [39:0] d;
    logic [15:0] c;
    d = {8'h01, 8'h41, {6'b0, ext, brk}, code, m_seq};
    c = crc16(d);
    for (int i = 0; i < 5; i++) exp_q.push_back(d[39 - 8*i -: 8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    m_seq = m_seq + 8'd1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit drop_f;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      drop_f = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      if (!m_brk) begin
        if (m_last_vld && m_last == {m_ext, b}) drop_f = 1'b1;
        else begin
          m_last = {m_ext, b};
          m_last_vld = 1'b1;
        end
      end else if (m_last_vld && m_last == {m_ext, b}) m_last_vld = 1'b0;
`endif
      if (!drop_f) begin
        if (m_queued >= 2) m_ovf = 1'b1;
        else begin
          m_queued++;
          model_frame(m_ext, m_brk, b);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_last_vld = 0; m_last = '0;
    m_seq = 8'h00; m_queued = 0;
    exp_q.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    bus_if.PS2_Data     = b;
    bus_if.PS2_Done_Sig = 1'b1;
    last_t0 = cyc + 1;
    @(posedge CLK);
    #1;
    bus_if.PS2_Done_Sig = 1'b0;
    model_byte(b);
  endtask

  task automatic send_event(input bit ext, input bit brk, input logic [7:0] code);
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(code);
  endtask

  // Wait for all expected bytes and an idle block, then compare in order.
  task automatic drain(input string tag);
    int budget, k, avail, n;
    budget = 300 + 25 * exp_q.size();
    k = 0;
    while ((got_q.size() - gp) < exp_q.size() && k < budget) begin
      @(posedge CLK);
      k++;
    end
    k = 0;
    while (bus_if.Busy_Sig !== 1'b0 && k < 200) begin
      @(posedge CLK);
      k++;
    end
    repeat (3) @(posedge CLK);
    #1;
    avail = got_q.size() - gp;
    n = exp_q.size();
    chk({tag, " byte count"}, avail, n);
    for (int i = 0; i < n; i++) begin
      if (i < avail) begin
        chk({tag, " frame byte"}, got_q[gp], exp_q[0]);
        gp++;
      end
      void'(exp_q.pop_front());
    end
    gp = got_q.size();
    m_queued = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  fi, k;
    bit  e, r;
    logic [7:0] c;

    RSTn = 1'b0;
    bus_if.PS2_Data     = 8'h00;
    bus_if.PS2_Done_Sig = 1'b0;
    model_reset();
    #1;
    chk("reset TX_Data", bus_if.TX_Data, 8'h00);
    chk("reset TX_En", bus_if.TX_En_Sig, 1'b0);
    chk("reset Busy", bus_if.Busy_Sig, 1'b0);
    chk("reset Overflow", bus_if.Overflow_Sig, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;

    // Plain make code with latency from queue write to first start pulse.
    fi = got_q.size();
    send_byte(8'h1C);
    repeat (4) @(posedge CLK);
    #1 chk("busy while framing", bus_if.Busy_Sig, 1'b1);
    drain("make 1C");
    if (got_cyc.size() > fi) chk("first TX_En latency", got_cyc[fi] - last_t0, 42);
    else chk("first TX_En latency", 0, 42);
    chk("busy after frame", bus_if.Busy_Sig, 1'b0);

    // Extended break: one frame with B2=03.
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext break 75");

    // Auto-repeat sequence, each event drained.
    send_byte(8'h1C); drain("typematic");
    send_byte(8'h1C); drain("typematic");
    send_byte(8'h1C); drain("typematic");
    send_byte(8'hF0); send_byte(8'h1C); drain("typematic");
    send_byte(8'h1C); drain("typematic");
    send_byte(8'h1C); drain("typematic");
    chk("typematic Overflow", bus_if.Overflow_Sig, m_ovf);

    // Overflow: three codes while frame for 11 is still in its CRC phase.
    send_byte(8'h11);
    repeat (2) @(posedge CLK);
    m_queued = 0;
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    #1 chk("overflow set", bus_if.Overflow_Sig, 1'b1);
    drain("overflow");
    chk("overflow sticky", bus_if.Overflow_Sig, 1'b1);

    // Reset during WAIT of byte 3.
    send_byte(8'h1C);
    k = 0;
    while ((got_q.size() - gp) < 4 && k < 300) begin
      @(posedge CLK);
      k++;
    end
    #2 RSTn = 1'b0;
    #1;
    chk("midreset TX_Data", bus_if.TX_Data, 8'h00);
    chk("midreset TX_En", bus_if.TX_En_Sig, 1'b0);
    chk("midreset Busy", bus_if.Busy_Sig, 1'b0);
    chk("midreset Overflow", bus_if.Overflow_Sig, 1'b0);
    model_reset();
    gp = got_q.size();
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (80) @(posedge CLK);
    #1 chk("no TX_En after reset", got_q.size() - gp, 0);
    gp = got_q.size();
    send_byte(8'h1C);
    drain("post reset seq 00");

    // Sequence wrap: 257 frames alternating make/break of 1C.
    for (int i = 0; i < 257; i++) begin
      send_event(1'b0, i[0], 8'h1C);
      drain("seq wrap");
    end

    // Randomized events, one or two back-to-back.
    for (int i = 0; i < 60; i++) begin
      int npair;
      npair = $urandom_range(1, 2);
      for (int j = 0; j < npair; j++) begin
        e = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        c = 8'($urandom_range(0, 255));
        if (c == 8'hE0 || c == 8'hF0) c = 8'h5A;
        send_event(e, r, c);
      end
      drain("random");
    end

    chk("final Overflow", bus_if.Overflow_Sig, m_ovf);
    repeat (100) @(posedge CLK);
    #1 chk("no stray bytes", got_q.size() - gp, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
